// File: rtl/sent_rx_decoder.sv
// Single-channel SENT receiver: measures falling-edge periods in ticks, decodes sync/status/data/CRC.
// Optional error counter built when SENT_RX_ERR_CNT_EN is defined; otherwise err_cnt reads 0.
module sent_rx_decoder #(
    parameter int CLK_FREQ = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_vld,
    input  logic        cfg_en,
    input  logic [7:0]  cfg_tick_us,
    input  logic [2:0]  cfg_data_len,
    input  logic        cfg_crc_mode,
    input  logic        sent_in,
    output logic        frame_vld,
    output logic [3:0]  frame_status,
    output logic [23:0] frame_data,
    output logic        frame_crc_ok,
    output logic        err_vld,
    output logic [1:0]  err_code,
    output logic [15:0] err_cnt
);
    localparam int          CLKS_PER_US   = CLK_FREQ / 1000000;
    localparam logic [15:0] TICK_CLKS_RST = 16'(3 * CLKS_PER_US);
    localparam logic [1:0]  ERR_RANGE     = 2'd1;
    localparam logic [1:0]  ERR_CRC       = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT   = 2'd3;

    typedef enum logic [2:0] {IDLE, HUNT, STATUS, DATA, CRC} state_t;

    function automatic logic [3:0] crc_tab(input logic [3:0] i);
        case (i)
            4'd0:  crc_tab = 4'd0;   4'd1:  crc_tab = 4'd13;
            4'd2:  crc_tab = 4'd7;   4'd3:  crc_tab = 4'd10;
            4'd4:  crc_tab = 4'd14;  4'd5:  crc_tab = 4'd3;
            4'd6:  crc_tab = 4'd9;   4'd7:  crc_tab = 4'd4;
            4'd8:  crc_tab = 4'd1;   4'd9:  crc_tab = 4'd12;
            4'd10: crc_tab = 4'd6;   4'd11: crc_tab = 4'd11;
            4'd12: crc_tab = 4'd15;  4'd13: crc_tab = 4'd2;
            4'd14: crc_tab = 4'd8;   default: crc_tab = 4'd5;
        endcase
    endfunction

    // Input synchronizer and falling-edge detect
    logic sync1, sync2, line_prev, edge_det;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0; sync2 <= 1'b0; line_prev <= 1'b0; edge_det <= 1'b0;
        end else begin
            sync1     <= sent_in;
            sync2     <= sync1;
            line_prev <= sync2;
            edge_det  <= line_prev & ~sync2;
        end
    end

    // Configuration
    logic        en_q, crc_mode_q;
    logic [2:0]  data_len_q;
    logic [15:0] tick_clks;
    logic [7:0]  tick_us_c;
    logic [2:0]  len_c;
    always_comb begin
        tick_us_c = cfg_tick_us;
        if (cfg_tick_us < 8'd3)       tick_us_c = 8'd3;
        else if (cfg_tick_us > 8'd90) tick_us_c = 8'd90;
        len_c = cfg_data_len;
        if (cfg_data_len == 3'd0)     len_c = 3'd1;
        else if (cfg_data_len > 3'd6) len_c = 3'd6;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0; crc_mode_q <= 1'b1; data_len_q <= 3'd6; tick_clks <= TICK_CLKS_RST;
        end else if (cfg_vld) begin
            en_q       <= cfg_en;
            crc_mode_q <= cfg_crc_mode;
            data_len_q <= len_c;
            tick_clks  <= 16'(32'(tick_us_c) * CLKS_PER_US);
        end
    end

    // Tick measurement; prescaler starts half a tick in so counts round to nearest
    logic [15:0] presc;
    logic [9:0]  tick_cnt;
    logic        edge_seen;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0; tick_cnt <= '0; edge_seen <= 1'b0;
        end else begin
            if (edge_det) begin
                presc    <= tick_clks >> 1;
                tick_cnt <= '0;
            end else if (presc >= tick_clks - 16'd1) begin
                presc <= '0;
                if (tick_cnt != 10'd1023) tick_cnt <= tick_cnt + 10'd1;
            end else begin
                presc <= presc + 16'd1;
            end
            if (cfg_vld || !en_q) edge_seen <= 1'b0;
            else if (edge_det)    edge_seen <= 1'b1;
        end
    end

    logic       pulse, is_nib, is_sync, timeout, last_nib, crc_ok;
    logic [3:0] nib, crc_acc, crc_exp, status_buf;
    logic [2:0] nib_idx;
    logic [23:0] data_buf;

    assign pulse    = edge_det & edge_seen & ~cfg_vld;
    assign is_nib   = (tick_cnt >= 10'd12) && (tick_cnt <= 10'd27);
    assign is_sync  = (tick_cnt >= 10'd52) && (tick_cnt <= 10'd60);
    assign timeout  = (tick_cnt == 10'd1023);
    assign nib      = 4'(tick_cnt - 10'd12);
    assign last_nib = (nib_idx == data_len_q - 3'd1);
    assign crc_exp  = crc_mode_q ? crc_tab(crc_acc) : crc_acc;
    assign crc_ok   = (nib == crc_exp);

    state_t     state_q, state_d;
    logic       frame_fire, err_fire;
    logic [1:0] err_code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        frame_fire = 1'b0;
        err_fire   = 1'b0;
        err_code_d = 2'd0;
        if (cfg_vld) begin
            state_d = cfg_en ? HUNT : IDLE;
        end else begin
            case (state_q)
                IDLE: if (en_q) state_d = HUNT;
                HUNT: begin
                    if (!en_q)                 state_d = IDLE;
                    else if (pulse && is_sync) state_d = STATUS;
                end
                default: begin
                    if (pulse) begin
                        if (!is_nib) begin
                            err_fire   = 1'b1;
                            err_code_d = ERR_RANGE;
                            state_d    = is_sync ? STATUS : HUNT;
                        end else if (state_q == STATUS) begin
                            state_d = DATA;
                        end else if (state_q == DATA) begin
                            if (last_nib) state_d = CRC;
                        end else begin
                            frame_fire = 1'b1;
                            state_d    = HUNT;
                            if (!crc_ok) begin
                                err_fire   = 1'b1;
                                err_code_d = ERR_CRC;
                            end
                        end
                    end else if (timeout) begin
                        err_fire   = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = HUNT;
                    end
                end
            endcase
        end
    end

    // Frame assembly and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_idx <= '0; crc_acc <= '0; data_buf <= '0; status_buf <= '0;
            frame_vld <= 1'b0; frame_status <= '0; frame_data <= '0; frame_crc_ok <= 1'b0;
            err_vld <= 1'b0; err_code <= '0;
        end else begin
            frame_vld <= frame_fire;
            err_vld   <= err_fire;
            if (err_fire) err_code <= err_code_d;
            if (frame_fire) begin
                frame_status <= status_buf;
                frame_data   <= data_buf;
                frame_crc_ok <= crc_ok;
            end
            if (pulse && is_sync) begin
                nib_idx  <= '0;
                crc_acc  <= 4'h5;
                data_buf <= '0;
            end else if (pulse && is_nib) begin
                if (state_q == STATUS) status_buf <= nib;
                if (state_q == DATA) begin
                    for (int i = 0; i < 6; i++)
                        if (nib_idx == 3'(i)) data_buf[23-4*i -: 4] <= nib;
                    crc_acc <= crc_tab(crc_acc) ^ nib;
                    nib_idx <= nib_idx + 3'd1;
                end
            end
        end
    end

`ifdef SENT_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               err_cnt_q <= '0;
        else if (cfg_vld)                         err_cnt_q <= '0;
        else if (err_vld && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/sent_rx_decoder.md
# sent_rx_decoder

- Single-channel SENT receiver: the receive-side counterpart of the SENT transmit channels that are configured from UDP parameter frames.
- Samples one SENT input pin and measures falling-edge-to-falling-edge pulse periods in ticks.
- Recognises the calibration/sync pulse and decodes the status nibble, 1–6 data nibbles and the CRC nibble.
- Checks the CRC and presents each frame as a one-cycle result strobe, laid out as the transmit-side data word.

## Interface
Parameters:
- CLK_FREQ, 100000000: module clock frequency in Hz.

Ports:
- clk  in  1  module clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_vld  in  1  one-cycle strobe; latches all cfg_* inputs.
- cfg_en  in  1  receiver enable.
- cfg_tick_us  in  8  tick length in us. Values below 3 are clamped to 3; values above 90 are clamped to 90.
- cfg_data_len  in  3  data nibbles per frame. 0 is treated as 1; values above 6 are treated as 6.
- cfg_crc_mode  in  1  0 = Legacy, 1 = Recommended.
- sent_in  in  1  SENT line, asynchronous to clk.
- frame_vld  out  1  one-cycle frame strobe.
- frame_status  out  4  status/communication nibble.
- frame_data  out  24  {nibble1..nibble6}. nibble1 is at [23:20]; unused low nibbles are 0.
- frame_crc_ok  out  1  received CRC equals computed CRC; qualified by frame_vld.
- err_vld  out  1  one-cycle error strobe.
- err_code  out  2  1 = nibble out of range, 2 = CRC mismatch, 3 = timeout.
- err_cnt  out  16  error counter (see Configuration).

## Operation
Input path:
- sent_in passes through a 2-FF synchronizer, then a falling-edge detect register.

Configuration registers:
- Reset values: en = 0, tick_us = 3, data_len = 6, crc_mode = 1.
- When cfg_vld is accepted, tick_clks = tick_us × (CLK_FREQ/1000000) is registered as a 16-bit value.

Tick measurement:
- On each detected edge: prescaler ← tick_clks/2 (floor) and tick_cnt ← 0.
- Each cycle the prescaler increments. When it reaches tick_clks−1 it wraps to 0 and tick_cnt increments (10 bits, saturating at 1023).
- The measured ticks for a pulse is the tick_cnt value at the closing edge. This rounds the pulse length to the nearest tick.
- An edge_seen flag is set by the first edge after reset, enable, or cfg_vld. The first edge only starts a measurement and is never decoded.

State machine:
- IDLE: entered when en = 0. Moves to HUNT when en = 1.
- HUNT: a pulse of 52..60 ticks moves to STATUS. Any other length (pause pulse, 12..768 ticks, or noise) is ignored.
- STATUS: a pulse of 12..27 ticks gives status = ticks−12; moves to DATA.
- DATA: nibble i = ticks−12 is stored at frame_data[23−4i -: 4]. After data_len nibbles, moves to CRC.
- CRC: received CRC = ticks−12. Outputs are updated, frame_vld pulses, and the machine returns to HUNT.
- Pulse outside 12..27 in STATUS, DATA or CRC: err_code 1. If the pulse is 52..60 ticks it is taken as a new sync and the machine moves to STATUS; otherwise it moves to HUNT. Partial frame data is discarded.
- Timeout: tick_cnt reaching 1023 in STATUS, DATA or CRC gives err_code 3 and a move to HUNT.

CRC:
- Polynomial x^4+x^3+x^2+1, seed 0x5.
- Per data nibble: crc ← T[crc] ^ nibble. T[i] = (i·x^4) mod poly, i.e. {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
- Recommended mode applies one additional step with nibble 0.
- The status nibble is excluded.
- On mismatch: frame_vld = 1, frame_crc_ok = 0, and err_vld pulses in the same cycle with err_code 2.

Reconfiguration and reset:
- cfg_vld mid-frame: the frame is aborted without error, edge_seen is cleared, and the machine moves to HUNT (or IDLE if en = 0).
- All outputs reset to 0.
- frame_status, frame_data and frame_crc_ok hold their values until the next frame_vld.

## Timing
- Synchronizer plus edge detect: an edge is flagged 3 clk cycles after the sent_in fall.
- frame_vld and err_vld rise 1 cycle after the flagged closing edge.
- frame_vld and err_vld are always single-cycle pulses.
- Back-to-back frames with no pause are supported: the CRC edge also starts the next sync measurement.
- An edge and a prescaler wrap in the same cycle: the edge wins, and the wrap is not counted into the new pulse.
- No backpressure: downstream logic must sample the frame on frame_vld.

## Configuration
- SENT_RX_ERR_CNT_EN defined: err_cnt increments on every err_vld, saturates at 0xFFFF, and is cleared by reset or cfg_vld.
- SENT_RX_ERR_CNT_EN undefined: err_cnt is tied to 0 and no counter logic is built.

## Test plan
1. Reset -> all outputs 0 and the state is IDLE. After cfg_vld with en = 1, tick_us = 3 and CLK_FREQ = 100 MHz, tick_clks = 300.
2. Legacy mode, len = 1: sync 56, status 17, nibble 12, CRC 15 ticks -> frame_vld, status 0x5, data 0x000000, crc_ok = 1. Same frame in Recommended mode with CRC 22 ticks -> crc_ok = 1.
3. Legacy frame as in scenario 2 but with CRC 16 ticks -> frame_vld with crc_ok = 0, plus err_vld with err_code 2.
4. Data pulse of 30 ticks -> err_code 1 and no frame_vld. A following pause of 200 ticks followed by a valid frame -> that frame decodes correctly.
5. Nibble pulse of 12 ticks minus 140 clks, and 27 ticks plus 140 clks -> decoded as 0x0 and 0xF.
6. cfg_vld mid-DATA -> no frame and no error, followed by correct decode of the next full frame. Line held high for 1100 ticks in DATA -> err_code 3.
